axi_read_responder: RTL and testbench

Slave-side AXI read-channel responder fronting a single-port synchronous SRAM. Accepts one AR request at a time and returns a 1–16 beat INCR burst on the R channel, driving RLAST on the final beat. RLAST is the end-of-transaction event that the interconnect's read arbiter uses to rotate its grant. Sits between the interconnect slave port and the memory macro wrapper.

---
 rtl/axi_pkg.sv | 21 ++
 rtl/axi_read_responder.sv | 126 ++++++++++++
 tb/tb_axi_read_responder.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_pkg.sv
// Shared types and constants for the AXI read responder.
//   state_t    : responder FSM states
//   RESP_OKAY  : only response code ever returned
//   BURST_INCR : the one burst type implemented (others treated as INCR)
//   DATA_W / ADDR_W : AXI data and address widths
package axi_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;

    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] BURST_INCR = 2'b01;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        LOAD  = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/axi_read_responder.sv
// AXI slave read responder in front of a single-port synchronous SRAM.
// One AR request at a time; returns a 1-16 beat INCR burst, 3 cycles per beat
// (ISSUE -> LOAD -> RESP), RLAST on the final beat.
// Ports:
//   ACLK, ARESETn                       clock, async active-low reset
//   ARID/ARADDR/ARLEN/ARSIZE/ARBURST    AR channel payload (ARSIZE/ARBURST ignored)
//   ARVALID/ARREADY                     AR handshake
//   RID/RDATA/RRESP/RLAST/RVALID/RREADY R channel
//   mem_cs/mem_oe/mem_addr/mem_rdata    SRAM port, data one cycle after issue
module axi_read_responder
    import axi_pkg::*;
#(
    parameter int unsigned ID_W   = 8,
    parameter int unsigned MEM_AW = 14
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    input  logic [ID_W-1:0]     ARID,
    input  logic [ADDR_W-1:0]   ARADDR,
    input  logic [3:0]          ARLEN,
    input  logic [2:0]          ARSIZE,
    input  logic [1:0]          ARBURST,
    input  logic                ARVALID,
    output logic                ARREADY,
    output logic [ID_W-1:0]     RID,
    output logic [DATA_W-1:0]   RDATA,
    output logic [1:0]          RRESP,
    output logic                RLAST,
    output logic                RVALID,
    input  logic                RREADY,
    output logic                mem_cs,
    output logic                mem_oe,
    output logic [MEM_AW-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_rdata
);

    state_t              state_q, state_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [3:0]          len_q, len_d;
    logic [3:0]          beat_q, beat_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                issue_d;
    logic [MEM_AW-1:0]   mem_addr_d;

    // Ignored request fields and address bits outside the SRAM word range.
    logic unused_bits;
    assign unused_bits = ^{ARSIZE, (ARBURST == BURST_INCR), addr_q[ADDR_W-1:MEM_AW+2], addr_q[1:0]};

    assign RRESP = RESP_OKAY;
    assign RID   = id_q;
    assign RDATA = rdata_q;

    // State and datapath registers; R/AR/SRAM controls are registered from next state.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q  <= IDLE;
            id_q     <= '0;
            addr_q   <= '0;
            len_q    <= '0;
            beat_q   <= '0;
            rdata_q  <= '0;
            ARREADY  <= 1'b1;
            RVALID   <= 1'b0;
            RLAST    <= 1'b0;
            mem_cs   <= 1'b0;
            mem_oe   <= 1'b0;
            mem_addr <= '0;
        end else begin
            state_q  <= state_d;
            id_q     <= id_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            beat_q   <= beat_d;
            rdata_q  <= rdata_d;
            ARREADY  <= (state_d == IDLE);
            RVALID   <= (state_d == RESP);
            RLAST    <= (state_d == RESP) && (beat_d == len_d);
            mem_cs   <= issue_d;
            mem_oe   <= issue_d;
            mem_addr <= mem_addr_d;
        end
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        addr_d     = addr_q;
        len_d      = len_q;
        beat_d     = beat_q;
        rdata_d    = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (ARVALID) begin
                    id_d    = ARID;
                    addr_d  = ARADDR;
                    len_d   = ARLEN;
                    beat_d  = 4'd0;
                    state_d = ISSUE;
                end
            end
            ISSUE: state_d = LOAD;
            LOAD: begin
                rdata_d = mem_rdata;
                state_d = RESP;
            end
            RESP: begin
                if (RREADY) begin
                    if (beat_q == len_q) begin
                        state_d = IDLE;
                    end else begin
                        addr_d  = ADDR_W'(addr_q + 32'd4);
                        beat_d  = 4'(beat_q + 4'd1);
                        state_d = ISSUE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        issue_d    = (state_d == ISSUE);
        // Word address wraps silently at the top of the SRAM.
        mem_addr_d = issue_d ? addr_d[MEM_AW+1:2] : mem_addr;
    end

endmodule

// File: tb/tb_axi_read_responder.sv
// Scoreboard bench for axi_read_responder: directed scenarios plus random bursts.
module tb_axi_read_responder;

    localparam int unsigned ID_W   = 8;
    localparam int unsigned MEM_AW = 14;
    localparam int unsigned DEPTH  = 1 << MEM_AW;

    logic              ACLK = 1'b0;
    logic              ARESETn;
    logic [ID_W-1:0]   ARID;
    logic [31:0]       ARADDR;
    logic [3:0]        ARLEN;
    logic [2:0]        ARSIZE;
    logic [1:0]        ARBURST;
    logic              ARVALID;
    logic              ARREADY;
    logic [ID_W-1:0]   RID;
    logic [31:0]       RDATA;
    logic [1:0]        RRESP;
    logic              RLAST;
    logic              RVALID;
    logic              RREADY;
    logic              mem_cs;
    logic              mem_oe;
    logic [MEM_AW-1:0] mem_addr;
    logic [31:0]       mem_rdata;

    axi_read_responder #(.ID_W(ID_W), .MEM_AW(MEM_AW)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
        .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
        .RVALID(RVALID), .RREADY(RREADY),
        .mem_cs(mem_cs), .mem_oe(mem_oe), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
    );

    always #5 ACLK = ~ACLK;

    // SRAM model: data one cycle after the issue cycle.
    logic [31:0] mem [DEPTH];
    always @(posedge ACLK) if (mem_cs && mem_oe) mem_rdata <= mem[mem_addr];

    typedef struct {
        logic [31:0]     data;
        logic [ID_W-1:0] id;
        logic            last;
    } beat_t;

    beat_t             exp_beats[$];
    logic [MEM_AW-1:0] exp_addrs[$];
    bit                busy = 0;
    int                cs_cnt = 0;
    int                beats_done = 0;
    int                n_checks = 0;
    int                n_pass = 0;
    int                rr_mode = 0;   // 0: RREADY high, 1: random, 2: stimulus-owned

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Reference: beat i of a burst reads word ((ARADDR + 4*i) / 4) mod DEPTH.
    task automatic push_expected(input logic [ID_W-1:0] id, input logic [31:0] addr, input logic [3:0] len);
        for (int i = 0; i <= int'(len); i++) begin
            logic [31:0] byte_addr;
            logic [MEM_AW-1:0] w;
            beat_t b;
            byte_addr = addr + 32'(4 * i);
            w = MEM_AW'(byte_addr >> 2);
            b.data = mem[w];
            b.id   = id;
            b.last = (i == int'(len));
            exp_addrs.push_back(w);
            exp_beats.push_back(b);
        end
    endtask

    // Monitor: samples on the falling edge, compares against the scoreboard.
    always @(negedge ACLK) begin
        if (ARESETn === 1'b1) begin
            check("arready_vs_busy", 64'(ARREADY), 64'(!busy));
            check("cs_eq_oe", 64'(mem_cs), 64'(mem_oe));
            if (RLAST) check("rlast_needs_rvalid", 64'(RVALID), 64'd1);
            if (mem_cs) begin
                cs_cnt++;
                if (exp_addrs.size() == 0) check("unexpected_mem_cs", 64'd1, 64'd0);
                else check("mem_addr", 64'(mem_addr), 64'(exp_addrs.pop_front()));
            end
            if (RVALID) begin
                if (exp_beats.size() == 0) begin
                    check("unexpected_rvalid", 64'd1, 64'd0);
                end else begin
                    beat_t e;
                    e = exp_beats[0];
                    check("rdata", 64'(RDATA), 64'(e.data));
                    check("rid_rlast_rresp", {RID, RLAST, RRESP}, {e.id, e.last, 2'b00});
                    if (RREADY) begin
                        void'(exp_beats.pop_front());
                        beats_done++;
                        if (e.last) busy = 0;
                    end
                end
            end
            if (ARVALID && ARREADY) begin
                push_expected(ARID, ARADDR, ARLEN);
                busy = 1;
            end
        end
    end

    // RREADY driver for modes 0 and 1.
    always @(posedge ACLK) begin
        #1;
        if (rr_mode == 0) RREADY = 1'b1;
        else if (rr_mode == 1) RREADY = ($urandom_range(0, 3) != 0);
    end

    task automatic send_ar(input logic [ID_W-1:0] id, input logic [31:0] addr, input logic [3:0] len);
        bit ok;
        ok = 0;
        @(posedge ACLK); #1;
        ARVALID = 1'b1; ARID = id; ARADDR = addr; ARLEN = len;
        ARSIZE = 3'(($urandom) & 32'h7); ARBURST = 2'(($urandom) & 32'h3);
        for (int n = 0; n < 400; n++) begin
            @(negedge ACLK);
            if (ARREADY) begin ok = 1; break; end
        end
        if (!ok) check("ar_accept_timeout", 64'd0, 64'd1);
        @(posedge ACLK); #1;
        ARVALID = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge ACLK);
            if (!busy && exp_beats.size() == 0 && !ARVALID) begin ok = 1; break; end
        end
        if (!ok) check("idle_timeout", 64'd0, 64'd1);
        @(posedge ACLK); #1;
    endtask

    initial begin
        int lat;
        int b0;
        bit ok;
        for (int i = 0; i < int'(DEPTH); i++) mem[i] = $urandom;
        mem[4] = 32'hDEADBEEF;
        ARESETn = 1'b0; ARVALID = 1'b0; ARID = '0; ARADDR = '0; ARLEN = '0;
        ARSIZE = '0; ARBURST = '0; RREADY = 1'b0;
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        check("rst_arready", 64'(ARREADY), 64'd1);
        check("rst_rvalid", 64'(RVALID), 64'd0);
        check("rst_rlast", 64'(RLAST), 64'd0);
        check("rst_rid_rdata_rresp", {RID, RDATA, RRESP}, 64'd0);
        check("rst_mem_ctl", {mem_cs, mem_oe, mem_addr}, 64'd0);
        ARESETn = 1'b1;

        // Single beat with latency.
        rr_mode = 0;
        send_ar(8'h5A, 32'h10, 4'd0);
        lat = 0; ok = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge ACLK); lat++;
            if (RVALID) begin ok = 1; break; end
        end
        check("first_beat_latency", 64'(ok ? lat : -1), 64'd3);
        check("single_rdata", 64'(RDATA), 64'hDEADBEEF);
        wait_idle();

        // Four-beat burst.
        cs_cnt = 0;
        send_ar(8'h11, 32'h100, 4'd3);
        wait_idle();
        check("burst4_cs_pulses", 64'(cs_cnt), 64'd4);

        // Backpressure on beat 2.
        rr_mode = 2; RREADY = 1'b1; cs_cnt = 0;
        b0 = beats_done;
        send_ar(8'h22, 32'h100, 4'd3);
        ok = 0;
        for (int n = 0; n < 50; n++) begin
            @(negedge ACLK);
            if (beats_done == b0 + 1) begin ok = 1; break; end
        end
        @(posedge ACLK); #1; RREADY = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge ACLK);
            if (RVALID) break;
        end
        repeat (5) @(posedge ACLK);
        #1; RREADY = 1'b1;
        check("bp_reached_beat2", 64'(ok), 64'd1);
        wait_idle();
        check("bp_cs_pulses", 64'(cs_cnt), 64'd4);
        rr_mode = 0;

        // Wrap at top of memory.
        send_ar(8'h33, 32'hFFF8, 4'd3);
        wait_idle();

        // Back-to-back: second request held while the first is in flight.
        send_ar(8'h44, 32'h200, 4'd2);
        send_ar(8'h55, 32'h300, 4'd1);
        wait_idle();

        // Reset during beat 2 of an 8-beat burst.
        b0 = beats_done;
        send_ar(8'h66, 32'h400, 4'd7);
        ok = 0;
        for (int n = 0; n < 50; n++) begin
            @(negedge ACLK);
            if (beats_done == b0 + 1 && RVALID) begin ok = 1; break; end
        end
        check("rst_mid_reached_beat2", 64'(ok), 64'd1);
        ARESETn = 1'b0;
        #1;
        check("rst_mid_rvalid", 64'(RVALID), 64'd0);
        check("rst_mid_arready", 64'(ARREADY), 64'd1);
        check("rst_mid_rlast", 64'(RLAST), 64'd0);
        exp_beats.delete(); exp_addrs.delete(); busy = 0;
        repeat (2) @(posedge ACLK);
        @(negedge ACLK); ARESETn = 1'b1;
        send_ar(8'h77, 32'h40, 4'd0);
        wait_idle();

        // Random bursts with random backpressure.
        rr_mode = 1;
        for (int k = 0; k < 25; k++) begin
            send_ar(ID_W'($urandom), $urandom, 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 1) == 0) wait_idle();
        end
        wait_idle();
        check("scoreboard_drained", 64'(exp_beats.size() + exp_addrs.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
